// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_wb_arbiter                                            |
// | Purpose  : Shares one register-file write port between the ALU result    |
// |            stream (highest priority, no backpressure) and a buffered     |
// |            load-return channel. Also keeps the load scoreboard and       |
// |            raises alu_stall when a buffered load starves.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,  // load-return buffer entries, power of 2
  parameter int STARVE_LIMIT = 4   // denied cycles before alu_stall
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  // pipeline result write
  input  logic        alu_we,
  input  logic [4:0]  alu_wa,
  input  logic [31:0] alu_wd,
  // load-return channel
  input  logic        ld_valid,
  input  logic [4:0]  ld_wa,
  input  logic [31:0] ld_wd,
  output logic        ld_ready,
  // load-issue marking
  input  logic        mark_valid,
  input  logic [4:0]  mark_wa,
  // regfile write port
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  // status
  output logic [31:0] busy,
  output logic        alu_stall
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4:0]        wa_mem_q [FIFO_DEPTH];
  logic [31:0]       wd_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic              ld_ready_q, ld_ready_d;

  logic              we_q,  we_d;
  logic [4:0]        wa_q,  wa_d;
  logic [31:0]       wd_q,  wd_d;

  logic [31:0]       busy_q, busy_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_q, stall_d;

  // ---------------------------------------------------------------------------
  // Arbitration terms
  // ---------------------------------------------------------------------------
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        alu_win;
  logic        head_win;
  logic [4:0]  head_wa;
  logic [31:0] head_wd;
  logic        head_writes;

  // Decide the single winner of this cycle's write slot.
  always_comb begin
    push        = ld_valid && ld_ready_q;
    fifo_empty  = (count_q == '0);
    head_wa     = wa_mem_q[rd_ptr_q];
    head_wd     = wd_mem_q[rd_ptr_q];
    // An ALU write to r0 is discarded and leaves the slot to the buffer.
    alu_win     = alu_we && (alu_wa != 5'd0);
    head_win    = !alu_win && !fifo_empty;
    pop         = head_win;
    // A winning head addressed to r0 is consumed but produces no write.
    head_writes = head_win && (head_wa != 5'd0);
  end

  // FIFO pointer and occupancy bookkeeping; ld_ready follows post-update fill.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    ld_ready_d = (count_d != FULL_CNT);
  end

  // Next value of the registered write port.
  always_comb begin
    we_d = 1'b0;
    wa_d = 5'd0;
    wd_d = 32'd0;
    if (alu_win) begin
      we_d = 1'b1;
      wa_d = alu_wa;
      wd_d = alu_wd;
    end else if (head_writes) begin
      we_d = 1'b1;
      wa_d = head_wa;
      wd_d = head_wd;
    end
  end

  // Scoreboard: clear on a load's win, then a same-cycle mark overrides it.
  always_comb begin
    busy_d = busy_q;
    if (head_win) begin
      busy_d[head_wa] = 1'b0;
    end
    if (mark_valid && (mark_wa != 5'd0)) begin
      busy_d[mark_wa] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Starvation tracking: count denied cycles of a waiting head, saturating.
  always_comb begin
    wait_d = wait_q;
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
    // The count only leaves WAIT_MAX through a pop, so stall holds until then.
    stall_d = (wait_d == WAIT_MAX);
  end

  // Buffer storage; contents are meaningless outside the pointer window.
  always_ff @(posedge cpu_clk_50M) begin
    if (push) begin
      wa_mem_q[wr_ptr_q] <= ld_wa;
      wd_mem_q[wr_ptr_q] <= ld_wd;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ld_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= 5'd0;
      wd_q       <= 32'd0;
      busy_q     <= 32'd0;
      wait_q     <= '0;
      stall_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ld_ready_q <= ld_ready_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      wait_q     <= wait_d;
      stall_q    <= stall_d;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign we        = we_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign busy      = busy_q;
  assign alu_stall = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_wb_arbiter                                         |
// | Purpose  : Self-checking bench: directed scenarios with literal          |
// |            expectations plus a long randomized run against a queue-based |
// |            reference model of the write-back arbiter.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        ld_valid;
  logic [4:0]  ld_wa;
  logic [31:0] ld_wd;
  logic        ld_ready;
  logic        mark_valid;
  logic [4:0]  mark_wa;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] busy;
  logic        alu_stall;

  regfile_wb_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .alu_we      (alu_we),
    .alu_wa      (alu_wa),
    .alu_wd      (alu_wd),
    .ld_valid    (ld_valid),
    .ld_wa       (ld_wa),
    .ld_wd       (ld_wd),
    .ld_ready    (ld_ready),
    .mark_valid  (mark_valid),
    .mark_wa     (mark_wa),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .busy        (busy),
    .alu_stall   (alu_stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what the visible outputs must be after each clock edge.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } beat_t;

  beat_t       m_q[$];
  bit          m_live  = 1'b0;
  logic        m_we    = 1'b0;
  logic [4:0]  m_wa    = '0;
  logic [31:0] m_wd    = '0;
  logic [31:0] m_busy  = '0;
  logic        m_ready = 1'b0;
  logic        m_stall = 1'b0;
  int          m_wait  = 0;

  task automatic model_update();
    bit    accept;
    bit    alu_ok;
    bit    load_win;
    bit    was_empty;
    beat_t h;
    if (rst) begin
      m_q.delete();
      m_live  = 1'b1;
      m_we    = 1'b0;
      m_wa    = '0;
      m_wd    = '0;
      m_busy  = '0;
      m_ready = 1'b0;
      m_stall = 1'b0;
      m_wait  = 0;
      return;
    end
    accept    = ld_valid && m_ready;
    alu_ok    = alu_we && (alu_wa != 5'd0);
    was_empty = (m_q.size() == 0);
    load_win  = !alu_ok && !was_empty;
    m_we = 1'b0;
    h    = '0;
    if (alu_ok) begin
      m_we = 1'b1;
      m_wa = alu_wa;
      m_wd = alu_wd;
    end else if (load_win) begin
      h = m_q.pop_front();
      if (h.wa != 5'd0) begin
        m_we = 1'b1;
        m_wa = h.wa;
        m_wd = h.wd;
      end
    end
    if (load_win) m_busy[h.wa] = 1'b0;
    if (mark_valid && mark_wa != 5'd0) m_busy[mark_wa] = 1'b1;
    m_busy[0] = 1'b0;
    if (was_empty || load_win) m_wait = 0;
    else m_wait = m_wait + 1;
    m_stall = (m_wait >= LIMIT);
    if (accept) m_q.push_back('{wa: ld_wa, wd: ld_wd});
    m_ready = (m_q.size() < DEPTH);
  endtask

  // Compare every cycle on the falling edge, once the model has seen a reset.
  always @(negedge clk) begin
    if (m_live) begin
      chk("we", 32'(we), 32'(m_we));
      if (m_we) begin
        chk("wa", 32'(wa), 32'(m_wa));
        chk("wd", wd, m_wd);
      end
      chk("busy", busy, m_busy);
      chk("alu_stall", 32'(alu_stall), 32'(m_stall));
      chk("ld_ready", 32'(ld_ready), 32'(m_ready));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle();
    alu_we = 0; alu_wa = '0; alu_wd = '0;
    ld_valid = 0; ld_wa = '0; ld_wd = '0;
    mark_valid = 0; mark_wa = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int alu_pct;
    rst = 1'b1;
    idle();
    step(); step();
    chk("rst_we",    32'(we), 0);
    chk("rst_wa",    32'(wa), 0);
    chk("rst_wd",    wd, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_stall", 32'(alu_stall), 0);
    chk("rst_ready", 32'(ld_ready), 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(ld_ready), 1);

    // ALU write visible for exactly one cycle
    alu_we = 1; alu_wa = 5'd5; alu_wd = 32'h1234_5678;
    step(); idle();
    chk("alu_we", 32'(we), 1);
    chk("alu_wa", 32'(wa), 5);
    chk("alu_wd", wd, 32'h1234_5678);
    step();
    chk("alu_we_once", 32'(we), 0);

    // Load path with scoreboard
    mark_valid = 1; mark_wa = 5'd7;
    step(); idle();
    chk("mark7", 32'(busy[7]), 1);
    ld_valid = 1; ld_wa = 5'd7; ld_wd = 32'hDEAD_BEEF;
    step(); idle();
    chk("ld_busy_n1", 32'(busy[7]), 1);
    chk("ld_we_n1",   32'(we), 0);
    step();
    chk("ld_we_n2", 32'(we), 1);
    chk("ld_wa_n2", 32'(wa), 7);
    chk("ld_wd_n2", wd, 32'hDEAD_BEEF);
    chk("ld_busy_n2", 32'(busy[7]), 0);
    step();

    // Fill the FIFO under continuous ALU traffic, then drain in order
    for (int i = 0; i < 4; i++) begin
      alu_we = 1; alu_wa = 5'd1; alu_wd = 32'(i);
      ld_valid = 1; ld_wa = 5'(10 + i); ld_wd = 32'hA000_0000 + 32'(i);
      step();
    end
    idle();
    chk("full_ready", 32'(ld_ready), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_we", 32'(we), 1);
      chk("drain_wa", 32'(wa), 32'(10 + i));
      chk("drain_wd", wd, 32'hA000_0000 + 32'(i));
      if (i == 0) chk("ready_after_pop", 32'(ld_ready), 1);
    end
    step();
    chk("drain_done", 32'(we), 0);

    // Starvation
    alu_we = 1; alu_wa = 5'd2; alu_wd = 32'h5;
    ld_valid = 1; ld_wa = 5'd9; ld_wd = 32'hCAFE_0009;
    step();
    ld_valid = 0;
    step(); step(); step();
    chk("stall_3", 32'(alu_stall), 0);
    step();
    chk("stall_4", 32'(alu_stall), 1);
    step();
    chk("stall_hold", 32'(alu_stall), 1);
    idle();
    step();
    chk("starve_we", 32'(we), 1);
    chk("starve_wa", 32'(wa), 9);
    chk("starve_wd", wd, 32'hCAFE_0009);
    chk("stall_drop", 32'(alu_stall), 0);

    // Register-0 rules
    alu_we = 1; alu_wa = 5'd0; alu_wd = 32'hFFFF_FFFF;
    step(); idle();
    chk("r0_alu", 32'(we), 0);
    ld_valid = 1; ld_wa = 5'd0; ld_wd = 32'h1111_1111;
    step(); idle();
    chk("r0_ld_a", 32'(we), 0);
    step();
    chk("r0_ld_b", 32'(we), 0);
    mark_valid = 1; mark_wa = 5'd0;
    step(); idle();
    chk("r0_mark", busy, 0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      alu_we = 1; alu_wa = 5'd3; alu_wd = 32'(i);
      ld_valid = 1; ld_wa = 5'(20 + i); ld_wd = 32'hB000_0000 + 32'(i);
      mark_valid = 1; mark_wa = 5'(20 + i);
      step();
    end
    idle();
    chk("pre_rst_busy", busy, 32'h0070_0000);
    rst = 1'b1;
    step();
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", 32'(ld_ready), 0);
    rst = 1'b0;
    step();
    chk("post_rst_we", 32'(we), 0);
    chk("post_rst_ready", 32'(ld_ready), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_nowrite", 32'(we), 0);
    end

    // Randomized traffic with varying ALU load
    alu_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: alu_pct = 10;
          1: alu_pct = 50;
          default: alu_pct = 95;
        endcase
      end
      rst        = ($urandom_range(0, 299) == 0);
      alu_we     = ($urandom_range(0, 99) < alu_pct);
      alu_wa     = rand_reg();
      alu_wd     = $urandom;
      ld_valid   = ($urandom_range(0, 99) < 60);
      ld_wa      = rand_reg();
      ld_wd      = $urandom;
      mark_valid = ($urandom_range(0, 99) < 30);
      mark_wa    = rand_reg();
      step();
    end
    rst = 1'b0;
    idle();
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, load-return buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, cycles a buffered load may be denied the write port before alu_stall is raised.
REQ-003 SHALL have port cpu_clk_50M  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port cpu_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports alu_we in 1, alu_wa in 5, and alu_wd in 32, carrying the pipeline result write, which has no backpressure.
REQ-006 SHALL have ports ld_valid in 1, ld_wa in 5, ld_wd in 32, and ld_ready out 1, forming the load-return valid/ready channel.
REQ-007 SHALL have ports mark_valid in 1 and mark_wa in 5, marking a load destination pending at load issue.
REQ-008 SHALL have ports we out 1, wa out 5, and wd out 32, driving the single regfile write port.
REQ-009 SHALL have port busy  out  32  scoreboard, bit r = load to register r outstanding.
REQ-010 SHALL have port alu_stall  out  1  request for upstream to withhold alu_we next cycle.

Function
REQ-011 SHALL accept a load beat when ld_valid && ld_ready in the same cycle, pushing {ld_wa, ld_wd} into the FIFO.
REQ-012 SHALL register ld_ready as !full, evaluated on post-update occupancy; push and pop in the same cycle leave the count unchanged.
REQ-013 SHALL not bypass the FIFO: a beat accepted in cycle N is eligible to win in N+1 at the earliest.
REQ-014 SHALL arbitrate once per cycle, with ALU write (alu_we && alu_wa!=0) first, then FIFO head if non-empty, else no write.
REQ-015 SHALL register outputs: the winner of cycle N appears on we/wa/wd in N+1 for exactly one cycle; we=0 otherwise.
REQ-016 SHALL pop the FIFO head in the cycle it wins; a head with wa=0 is popped and dropped with we=0 in the next cycle.
REQ-017 SHALL drop alu_we with alu_wa=0 without consuming the write slot.
REQ-018 SHALL preserve load ordering: FIFO entries drain strictly in acceptance order, including wrap-around of read/write pointers.
REQ-019 SHALL set busy[mark_wa] on mark_valid; mark_wa=0 is ignored and busy[0] is constantly 0.
REQ-020 SHALL clear busy[r] in the cycle a FIFO entry for r wins arbitration.
REQ-021 SHALL let set win over clear when mark and clear target the same register in one cycle.
REQ-022 SHALL treat alu_we to a register with busy=1 as an upstream protocol violation, and SHALL still perform the write as specified.
REQ-023 SHALL keep a wait counter: it increments each cycle the FIFO is non-empty and the head loses, and it clears on head pop or when the FIFO is empty.
REQ-024 SHALL register alu_stall=1 in the cycle after the wait counter reaches STARVE_LIMIT, and hold it until the head pops.
REQ-025 SHALL not gate the ALU with alu_stall internally; ALU priority is unchanged.

Reset
REQ-026 SHALL, while cpu_rst=1, force we=0, wa=0, wd=0, busy=0, alu_stall=0, ld_ready=0, FIFO empty, pointers and wait counter 0.
REQ-027 SHALL discard FIFO contents and in-flight winners on reset asserted mid-operation; no write occurs in the cycle after a reset cycle.
REQ-028 SHALL raise ld_ready in the first cycle after cpu_rst deasserts.

Verification
REQ-029 SHALL verify ALU write: alu_we=1, alu_wa=5, alu_wd=0x12345678 in cycle N -> we=1, wa=5, wd=0x12345678 in N+1 only.
REQ-030 SHALL verify load path: mark 7, then ld beat {7, 0xDEADBEEF} at N with alu idle -> busy[7]=1 until N+1, we/wa/wd = 1/7/0xDEADBEEF at N+2, busy[7]=0 from N+2.
REQ-031 SHALL verify full FIFO: 4 beats while alu_we=1 every cycle -> ld_ready=0 after the 4th; writes drain in order once the ALU idles; ld_ready=1 after the first pop.
REQ-032 SHALL verify starvation: one buffered beat with alu_we=1 continuously -> alu_stall=1 after 4 denied cycles; ALU idle one cycle -> load written and alu_stall drops.
REQ-033 SHALL verify register-0 rules: alu_wa=0 and ld_wa=0 beats -> no we pulse; mark_wa=0 -> busy stays 0.
REQ-034 SHALL verify reset mid-stream: 3 beats buffered, cpu_rst pulsed 1 cycle -> no writes follow, busy=0, ld_ready=0 then 1.
